// File: rtl/tri_pair_collector.sv
// tri_pair_collector
// Accepts candidate triangles over valid/ready and checks each one for a
// right angle with an iterative shift-add datapath:
// leg0^2 + leg1^2 - hyp^2 == 0, with all sides nonzero.
// Failing candidates are dropped with a reject pulse and a saturating count.
// Passing candidates are paired in arrival order and held on a..f until the
// downstream comparator consumes the pair.
module tri_pair_collector (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] in_leg0,
    input  logic [8:0] in_leg1,
    input  logic [8:0] in_hyp,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] a,
    output logic [8:0] b,
    output logic [8:0] c,
    output logic [8:0] d,
    output logic [8:0] e,
    output logic [8:0] f,
    output logic       reject,
    output logic [7:0] reject_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // One partial-product row of v*v: (v[idx] ? v << idx : 0), zero-extended
    // into the signed accumulator width. Largest row is 511 << 8, which
    // stays well inside the positive range of the 21-bit accumulator.
    function automatic logic signed [20:0] bit_term(input logic [8:0] v,
                                                    input logic [3:0] idx);
        logic [20:0] ext;
        ext = {12'd0, v} << idx;
        if (v[idx]) begin
            bit_term = $signed(ext);
        end else begin
            bit_term = 21'sd0;
        end
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_ready;
    logic [8:0]          r_leg0;
    logic [8:0]          r_leg1;
    logic [8:0]          r_hyp;
    logic signed [20:0]  r_acc;
    logic [3:0]          r_i;
    logic                r_pair_half;
    logic                r_out_valid;
    logic [8:0]          r_a;
    logic [8:0]          r_b;
    logic [8:0]          r_c;
    logic [8:0]          r_d;
    logic [8:0]          r_e;
    logic [8:0]          r_f;
    logic                r_reject;
    logic [7:0]          r_reject_cnt;

    logic                w_accept;
    logic                w_pass;
    logic                w_fail;
    logic                w_consume;
    logic                w_all_nz;
    logic signed [20:0]  w_t0;
    logic signed [20:0]  w_t1;
    logic signed [20:0]  w_t2;
    logic signed [20:0]  w_acc_nxt;

    // Next-state logic, handshake decode and the accumulator update value.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_pass      = 1'b0;
        w_fail      = 1'b0;
        w_consume   = 1'b0;
        w_all_nz    = (r_leg0 != 9'd0) && (r_leg1 != 9'd0) && (r_hyp != 9'd0);
        w_t0        = bit_term(r_leg0, r_i);
        w_t1        = bit_term(r_leg1, r_i);
        w_t2        = bit_term(r_hyp, r_i);
        w_acc_nxt   = r_acc + w_t0 + w_t1 - w_t2;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_CALC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (r_i == 4'd8) begin
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CHECK: begin
                if ((r_acc == 21'sd0) && w_all_nz) begin
                    w_pass = 1'b1;
                    if (r_pair_half) begin
                        w_state_nxt = ST_OUT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_fail      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_consume   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_OUT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; in_ready is registered from the next state so it is
    // high exactly while the machine sits in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == ST_IDLE);
        end
    end

    // Working registers: capture the candidate on acceptance, then run the
    // nine shift-add iterations of the squared-difference accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_leg0 <= 9'd0;
            r_leg1 <= 9'd0;
            r_hyp  <= 9'd0;
            r_acc  <= 21'sd0;
            r_i    <= 4'd0;
        end else if (w_accept) begin
            r_leg0 <= in_leg0;
            r_leg1 <= in_leg1;
            r_hyp  <= in_hyp;
            r_acc  <= 21'sd0;
            r_i    <= 4'd0;
        end else if (r_state == ST_CALC) begin
            r_acc <= w_acc_nxt;
            r_i   <= r_i + 4'd1;
        end
    end

    // Pair slot: first pass fills a,b,c; second fills d,e,f and raises
    // out_valid, which drops on the consuming handshake. a..f keep their
    // last values afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= 9'd0;
            r_b         <= 9'd0;
            r_c         <= 9'd0;
            r_d         <= 9'd0;
            r_e         <= 9'd0;
            r_f         <= 9'd0;
            r_pair_half <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_pass && !r_pair_half) begin
            r_a         <= r_leg0;
            r_b         <= r_leg1;
            r_c         <= r_hyp;
            r_pair_half <= 1'b1;
        end else if (w_pass && r_pair_half) begin
            r_d         <= r_leg0;
            r_e         <= r_leg1;
            r_f         <= r_hyp;
            r_pair_half <= 1'b0;
            r_out_valid <= 1'b1;
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end
    end

    // Rejection pulse and saturating rejection counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reject     <= 1'b0;
            r_reject_cnt <= 8'd0;
        end else begin
            r_reject <= w_fail;
            if (w_fail && (r_reject_cnt != 8'd255)) begin
                r_reject_cnt <= r_reject_cnt + 8'd1;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign a          = r_a;
    assign b          = r_b;
    assign c          = r_c;
    assign d          = r_d;
    assign e          = r_e;
    assign f          = r_f;
    assign reject     = r_reject;
    assign reject_cnt = r_reject_cnt;

endmodule

// File: tb/tb_tri_pair_collector.sv
// Scoreboard bench for tri_pair_collector: the stimulus side evaluates each
// accepted candidate arithmetically and queues the expected pair / reject
// event; an independent monitor compares whatever the DUT presents.
module tb_tri_pair_collector;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_leg0;
    logic [8:0] in_leg1;
    logic [8:0] in_hyp;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] a, b, c, d, e, f;
    logic       reject;
    logic [7:0] reject_cnt;

    tri_pair_collector dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_leg0    (in_leg0),
        .in_leg1    (in_leg1),
        .in_hyp     (in_hyp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .e          (e),
        .f          (f),
        .reject     (reject),
        .reject_cnt (reject_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    bit rand_ready = 1'b0;

    // Reference model state
    logic [53:0] exp_pairs[$];
    int          exp_rejs[$];
    bit          held_valid = 1'b0;
    logic [26:0] held;
    int          rej_model = 0;

    int trip[10][3] = '{'{3,4,5}, '{5,12,13}, '{8,15,17}, '{7,24,25},
                        '{20,21,29}, '{280,351,449}, '{6,8,10}, '{9,12,15},
                        '{119,120,169}, '{65,72,97}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: a right triangle by plain arithmetic, paired in arrival order.
    task automatic model(input int l0, input int l1, input int h);
        bit ok;
        ok = (l0 != 0) && (l1 != 0) && (h != 0) && (l0*l0 + l1*l1 == h*h);
        if (ok) begin
            if (held_valid) begin
                exp_pairs.push_back({held, l0[8:0], l1[8:0], h[8:0]});
                held_valid = 1'b0;
            end else begin
                held = {l0[8:0], l1[8:0], h[8:0]};
                held_valid = 1'b1;
            end
        end else begin
            if (rej_model < 255) rej_model++;
            exp_rejs.push_back(rej_model);
        end
    endtask

    task automatic send(input int l0, input int l1, input int h);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            in_valid = 1'b1;
            in_leg0  = l0[8:0];
            in_leg1  = l1[8:0];
            in_hyp   = h[8:0];
            @(posedge clk);
            model(l0, l1, h);
            #1;
            acc_cyc  = cyc;
            in_valid = 1'b0;
            in_leg0  = 9'($urandom);
            in_leg1  = 9'($urandom);
            in_hyp   = 9'($urandom);
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        out_ready = v;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_pairs.size() != 0 || exp_rejs.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pairs", exp_pairs.size(), 0);
        chk("drain_rejects", exp_rejs.size(), 0);
    endtask

    task automatic wait_reject(input string name, input int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!reject && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, cyc + 1 - acc_cyc, lat);
    endtask

    // Random out_ready while enabled; changed just after the active edge.
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom);
    end

    // Monitor: compares every presented pair and reject pulse to the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) chk("in_ready_low_in_out", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_pairs.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pair_unexpected actual=%0d,%0d,%0d/%0d,%0d,%0d expected=none",
                             a, b, c, d, e, f);
                end else begin
                    logic [53:0] ex;
                    ex = exp_pairs.pop_front();
                    chk("pair_abcdef", {a, b, c, d, e, f}, ex);
                end
            end
            if (reject) begin
                if (exp_rejs.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL reject_unexpected actual=1 expected=0 at cycle %0d", cyc);
                end else begin
                    chk("reject_cnt", reject_cnt, exp_rejs.pop_front());
                end
            end
        end
    end

    initial begin
        int t0, n, k, s;
        rst = 1'b1;
        in_valid = 1'b0;
        in_leg0 = 9'd0;
        in_leg1 = 9'd0;
        in_hyp  = 9'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_abcdef", {a, b, c, d, e, f}, 0);
        chk("rst_reject", reject, 0);
        chk("rst_reject_cnt", reject_cnt, 0);
        rst = 1'b0;

        // Basic pair with latency
        send(3, 4, 5);
        t0 = acc_cyc;
        send(5, 12, 13);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("pair_latency", cyc + 1 - t0, 22);

        // Rejection in the middle
        send(3, 4, 5);
        send(3, 4, 6);
        wait_reject("reject_latency", 11);
        chk("reject_cnt_after_mid", reject_cnt, 1);
        send(8, 15, 17);

        // Zero side
        send(0, 5, 5);
        wait_reject("zero_reject_latency", 11);
        chk("reject_cnt_after_zero", reject_cnt, 2);

        // Large values and field order
        send(280, 351, 449);
        send(511, 0, 511);
        send(449, 280, 351);
        send(3, 4, 5);
        drain();
        chk("reject_cnt_after_large", reject_cnt, 4);

        // Back-pressure
        set_ready(1'b0);
        send(20, 21, 29);
        send(7, 24, 25);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_leg0 = 9'd6; in_leg1 = 9'd8; in_hyp = 9'd10;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_abcdef", {a, b, c, d, e, f},
                {9'd20, 9'd21, 9'd29, 9'd7, 9'd24, 9'd25});
            @(negedge clk);
        end
        in_valid = 1'b0;
        set_ready(1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        drain();

        // Randomized candidates with random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 120; i++) begin
            s = $urandom_range(0, 9);
            case ($urandom_range(0, 5))
                0: send(trip[s][0], trip[s][1], trip[s][2]);
                1: begin
                    k = $urandom_range(1, 102);
                    send(3*k, 4*k, 5*k);
                end
                2: send(trip[s][1], trip[s][0], trip[s][2]);
                3: send(trip[s][2], trip[s][0], trip[s][1]);
                4: send($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511));
                default: send(trip[s][0], trip[s][1], trip[s][2] + $urandom_range(0, 1) - 1);
            endcase
        end
        drain();
        rand_ready = 1'b0;
        set_ready(1'b1);

        // Counter saturation
        for (int i = 0; i < 260; i++) begin
            send(1, 1, $urandom_range(1, 511));
        end
        drain();
        chk("reject_cnt_saturated", reject_cnt, 255);

        // Reset in the middle of the second candidate's CALC
        send(3, 4, 5);
        send(5, 12, 13);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        exp_pairs.delete();
        exp_rejs.delete();
        held_valid = 1'b0;
        rej_model = 0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_abcdef", {a, b, c, d, e, f}, 0);
        chk("mid_rst_reject", reject, 0);
        chk("mid_rst_reject_cnt", reject_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        send(6, 8, 10);
        send(9, 12, 15);
        drain();
        chk("post_rst_reject_cnt", reject_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tri_pair_collector.md
# tri_pair_collector

Upstream feeder for the right-triangle area comparator. It accepts candidate triangles one at a time over a valid/ready handshake and checks each for a right angle (leg0² + leg1² == hyp², all sides nonzero) with an iterative shift-add datapath. Rejected candidates are dropped. Accepted ones are paired in arrival order, and each pair is presented as registered a,b,c,d,e,f to the combinational comparator stage.

## Interface
- No parameters; all side widths are fixed at 9 bits to match the comparator inputs.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  candidate triangle present
- in_ready  output  1  block can accept a candidate this cycle
- in_leg0, in_leg1  input  9 each  candidate legs, unsigned
- in_hyp  input  9  candidate hypotenuse, unsigned
- out_valid  output  1  pair held on a..f
- out_ready  input  1  downstream consumes the pair
- a, b, c  output  9 each  first accepted triangle: leg0, leg1, hyp
- d, e, f  output  9 each  second accepted triangle: leg0, leg1, hyp
- reject  output  1  one-cycle pulse when a candidate fails the check
- reject_cnt  output  8  count of rejections, saturates at 255

## Operation
- States: IDLE, CALC, CHECK, OUT. Reset state is IDLE.
- IDLE
  - in_ready = 1.
  - On in_valid & in_ready, latch the three inputs into working registers, clear the accumulator, set the iteration counter i = 0, and go to CALC.
- CALC (9 cycles, i = 0..8)
  - acc += (leg0[i] ? leg0<<i : 0) + (leg1[i] ? leg1<<i : 0) − (hyp[i] ? hyp<<i : 0).
  - acc is 21-bit signed; no overflow is possible over the full input range.
  - Go to CHECK after i = 8.
- CHECK (1 cycle)
  - The candidate passes iff acc == 0 and leg0, leg1 and hyp are all nonzero.
  - Pass with slot empty: store into a,b,c and set pair_half = 1. Next state is IDLE.
  - Pass with pair_half = 1: store into d,e,f, clear pair_half, set out_valid. Next state is OUT.
  - Fail: pulse reject, increment reject_cnt unless it is already 255. Next state is IDLE. Slot contents are untouched.
- OUT
  - in_ready = 0.
  - a..f and out_valid are held stable while out_ready = 0.
  - On out_valid & out_ready, clear out_valid and go to IDLE. a..f keep their last values; they are don't-care while out_valid = 0.
- in_ready is 0 in CALC, CHECK and OUT.
- Input values are only sampled on the acceptance edge; input changes at any other time are ignored.
- Leg order is preserved exactly as presented; the block never swaps legs.

## Timing
- All outputs are registered. Reset value of every output: in_ready = 1 (IDLE), out_valid = 0, a..f = 0, reject = 0, reject_cnt = 0.
- Acceptance edge E. CALC occupies edges E+1..E+9. The CHECK decision is taken on edge E+10.
- reject or out_valid becomes visible in the cycle after E+10.
- in_ready returns high in that same cycle, unless the state is OUT.
- Throughput is one candidate per 11 cycles. Minimum pair latency from the first acceptance to out_valid is 22 edges.
- A pair is consumed on the first edge where out_valid & out_ready. in_ready rises the cycle after.
- out_ready is ignored whenever out_valid = 0.
- Asserting rst at any point (mid-CALC, half pair held, OUT with a pair pending) immediately returns to the reset values. The partial pair and the pending pair are discarded and reject_cnt is cleared.

## Test plan
- Basic pair: (3,4,5) then (5,12,13), out_ready = 1 → out_valid 22 edges after the first accept; a=3, b=4, c=5, d=5, e=12, f=13; reject stays 0.
- Rejection in the middle: (3,4,5), (3,4,6), (8,15,17) → one reject pulse 11 edges after the 2nd accept; reject_cnt = 1; pair = (3,4,5)/(8,15,17).
- Zero side: (0,5,5) → rejected even though the squares balance; reject_cnt increments.
- Large values: (280,351,449) then (511,0,511) then (449,280,351) → first accepted; second rejected (zero leg); third rejected, because the hypotenuse is not the last field.
- Back-pressure: complete a pair, hold out_ready = 0 for 5 cycles → a..f and out_valid stable, in_ready = 0 throughout, in_valid ignored; release out_ready → handshake completes in 1 cycle.
- Reset mid-operation: assert rst during CALC of the 2nd candidate → all outputs at reset values the same cycle; after release, a new pair (6,8,10)/(9,12,15) is produced correctly with no residue from before.
